sdspi_writer: RTL and testbench

SDSPI_WRITER -- requirements
Module: sdspi_writer

---
 rtl/sdspi_writer.sv | 236 +++++++++++++++++++++++
 tb/tb_sdspi_writer.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdspi_writer.sv
// Writes one 512-byte sector to an SD-over-SPI controller: bytes are fetched from a source,
// copied into the controller buffer over APB, then the sector write command is issued.
module sdspi_writer #(
    parameter logic [15:0] BLOCKADDR  = 16'h0200,
    parameter logic [15:0] WRCMD_ADDR = 16'h0004,
    parameter int          BLOCKSIZE  = 512,
    parameter int          TIMEOUT    = 65535
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wstart,
    input  logic [31:0] wsector,
    output logic        wdone,
    output logic        werr,
    output logic        inreq,
    output logic [8:0]  inaddr,
    input  logic        invalid,
    input  logic [7:0]  inbyte,
    output logic        psel,
    output logic        penable,
    output logic        pwrite,
    output logic [15:0] paddr,
    output logic [31:0] pwdata,
    input  logic [31:0] prdata,
    input  logic        pready,
    input  logic        pslverr,
    input  logic        sdsbusy,
    input  logic [31:0] sdspi_status,
    output logic [31:0] w_writer_status
);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_FETCH   = 4'd1,
        S_BSETUP  = 4'd2,
        S_BACCESS = 4'd3,
        S_NEXT    = 4'd4,
        S_CSETUP  = 4'd5,
        S_CACCESS = 4'd6,
        S_WBUSY   = 4'd7,
        S_WDONE   = 4'd8,
        S_FIN     = 4'd9,
        S_HOLD    = 4'd10
    } state_t;

    localparam logic [9:0]  LAST_COUNT = 10'(BLOCKSIZE);
    localparam logic [15:0] TMO_LAST   = 16'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [9:0]  count_q, count_d;
    logic [15:0] tmo_q, tmo_d;
    logic [7:0]  byte_q, byte_d;
    logic [31:0] sector_q, sector_d;
    logic        werr_q, werr_d;

    logic        psel_q, psel_d;
    logic        penable_q, penable_d;
    logic        pwrite_q, pwrite_d;
    logic [15:0] paddr_q, paddr_d;
    logic [31:0] pwdata_q, pwdata_d;
    logic        inreq_q, inreq_d;
    logic [8:0]  inaddr_q, inaddr_d;
    logic        wdone_q, wdone_d;

    logic        ctrl_idle_s;
    logic        unused_s;

    assign ctrl_idle_s = (!sdsbusy) && (sdspi_status[15:0] == 16'h0000);
    assign unused_s    = ^{prdata, sdspi_status[31:16]};

    // Next-state and datapath updates
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        tmo_d    = tmo_q;
        byte_d   = byte_q;
        sector_d = sector_q;
        werr_d   = werr_q;
        case (state_q)
            S_IDLE: begin
                if (wstart && ctrl_idle_s) begin
                    sector_d = wsector;
                    werr_d   = 1'b0;
                    count_d  = 10'd0;
                    tmo_d    = 16'd0;
                    state_d  = S_FETCH;
                end else begin
                    state_d  = S_IDLE;
                end
            end
            S_FETCH: begin
                if (invalid) begin
                    byte_d  = inbyte;
                    state_d = S_BSETUP;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_BSETUP: state_d = S_BACCESS;
            S_BACCESS: begin
                if (pready && pslverr) begin
                    werr_d  = 1'b1;
                    state_d = S_FIN;
                end else if (pready) begin
                    state_d = S_NEXT;
                end else begin
                    state_d = S_BACCESS;
                end
            end
            S_NEXT: begin
                count_d = count_q + 10'd1;
                if ((count_q + 10'd1) == LAST_COUNT) begin
                    state_d = S_CSETUP;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_CSETUP: state_d = S_CACCESS;
            S_CACCESS: begin
                if (pready && pslverr) begin
                    werr_d  = 1'b1;
                    state_d = S_FIN;
                end else if (pready) begin
                    tmo_d   = 16'd0;
                    state_d = S_WBUSY;
                end else begin
                    state_d = S_CACCESS;
                end
            end
            S_WBUSY: begin
                if (sdsbusy) begin
                    state_d = S_WDONE;
                end else if (tmo_q == TMO_LAST) begin
                    werr_d  = 1'b1;
                    state_d = S_FIN;
                end else begin
                    tmo_d   = tmo_q + 16'd1;
                end
            end
            S_WDONE: begin
                if (ctrl_idle_s) begin
                    state_d = S_FIN;
                end else begin
                    state_d = S_WDONE;
                end
            end
            S_FIN: state_d = S_HOLD;
            S_HOLD: begin
                if (!wstart) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_HOLD;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they register in step with it
    always_comb begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        pwrite_d  = 1'b0;
        paddr_d   = 16'h0000;
        pwdata_d  = 32'h0000_0000;
        inreq_d   = 1'b0;
        inaddr_d  = count_d[8:0];
        wdone_d   = 1'b0;
        case (state_d)
            S_FETCH: inreq_d = 1'b1;
            S_BSETUP, S_BACCESS: begin
                psel_d    = 1'b1;
                penable_d = (state_d == S_BACCESS);
                pwrite_d  = 1'b1;
                paddr_d   = BLOCKADDR + {6'b000000, count_d};
                pwdata_d  = {24'h000000, byte_d};
            end
            S_CSETUP, S_CACCESS: begin
                psel_d    = 1'b1;
                penable_d = (state_d == S_CACCESS);
                pwrite_d  = 1'b1;
                paddr_d   = WRCMD_ADDR;
                pwdata_d  = sector_d;
            end
            S_FIN: wdone_d = 1'b1;
            default: wdone_d = 1'b0;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            count_q   <= 10'd0;
            tmo_q     <= 16'd0;
            byte_q    <= 8'h00;
            sector_q  <= 32'h0000_0000;
            werr_q    <= 1'b0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= 16'h0000;
            pwdata_q  <= 32'h0000_0000;
            inreq_q   <= 1'b0;
            inaddr_q  <= 9'd0;
            wdone_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            tmo_q     <= tmo_d;
            byte_q    <= byte_d;
            sector_q  <= sector_d;
            werr_q    <= werr_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            inreq_q   <= inreq_d;
            inaddr_q  <= inaddr_d;
            wdone_q   <= wdone_d;
        end
    end

    assign psel            = psel_q;
    assign penable         = penable_q;
    assign pwrite          = pwrite_q;
    assign paddr           = paddr_q;
    assign pwdata          = pwdata_q;
    assign inreq           = inreq_q;
    assign inaddr          = inaddr_q;
    assign wdone           = wdone_q;
    assign werr            = werr_q;
    assign w_writer_status = {4'h0, state_q, werr_q, 7'h00, 6'h00, count_q};

endmodule

// File: tb/tb_sdspi_writer.sv
// Bench for sdspi_writer: random-latency byte source, APB slave with scoreboard and
// an SD controller busy model; scenarios come from a vector table plus hand sequences.
module tb_sdspi_writer;

    localparam logic [15:0] BLOCKADDR  = 16'h0200;
    localparam logic [15:0] WRCMD_ADDR = 16'h0004;
    localparam int          NO_ERR     = 9999;

    logic        clk = 1'b0;
    logic        rst;
    logic        wstart;
    logic [31:0] wsector;
    logic        wdone, werr, inreq;
    logic [8:0]  inaddr;
    logic        invalid;
    logic [7:0]  inbyte;
    logic        psel, penable, pwrite;
    logic [15:0] paddr;
    logic [31:0] pwdata, prdata;
    logic        pready, pslverr, sdsbusy;
    logic [31:0] sdspi_status, w_writer_status;

    sdspi_writer #(.BLOCKADDR(BLOCKADDR), .WRCMD_ADDR(WRCMD_ADDR), .BLOCKSIZE(512), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .wstart(wstart), .wsector(wsector), .wdone(wdone), .werr(werr),
        .inreq(inreq), .inaddr(inaddr), .invalid(invalid), .inbyte(inbyte),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .prdata(prdata), .pready(pready), .pslverr(pslverr), .sdsbusy(sdsbusy),
        .sdspi_status(sdspi_status), .w_writer_status(w_writer_status)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] sector;
        int          ws;
        int          err_idx;
        bit          busy_en;
        int          tail;
        bit          exp_werr;
        int          exp_bytes;
        int          exp_apb;
        int          exp_count;
    } vec_t;

    vec_t        vecs[6];
    int          n_pass = 0, n_total = 0;
    int          cyc = 0;
    int          cfg_ws = 0, cfg_err = NO_ERR, cfg_tail = 0;
    bit          cfg_busy_en = 1'b1;
    logic [31:0] cur_sector = 32'h0;
    int          exp_idx = 0, bytes_dlv = 0, apb_cnt = 0;
    int          cmd_cyc = 0, clr_cyc = 0;
    logic [47:0] sb_q[$];
    bit          force_busy = 1'b0;
    logic [31:0] force_status = 32'h0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Byte source: answers each request after 0-3 cycles, throws stray valids when idle
    initial begin
        invalid = 1'b0;
        inbyte  = 8'h00;
        forever begin
            @(negedge clk);
            invalid = 1'b0;
            if (inreq === 1'b1) begin
                int d;
                chk("inaddr", inaddr, exp_idx);
                d = $urandom_range(0, 3);
                while (d > 0 && inreq === 1'b1) begin
                    @(negedge clk);
                    d--;
                end
                if (inreq === 1'b1) begin
                    invalid = 1'b1;
                    inbyte  = 8'(exp_idx);
                    sb_q.push_back({BLOCKADDR + 16'(exp_idx), 24'h000000, 8'(exp_idx)});
                    if (exp_idx == 511) sb_q.push_back({WRCMD_ADDR, cur_sector});
                    exp_idx++;
                    bytes_dlv++;
                end
            end else if ($urandom_range(0, 5) == 0) begin
                invalid = 1'b1;
                inbyte  = 8'hEE;
            end
        end
    end

    // APB slave + scoreboard, and the controller busy model
    initial begin
        int          wcnt, bphase, bcnt;
        bit          setup_prev, busy_m;
        logic [15:0] la;
        logic [31:0] ld, status_m;
        logic [47:0] e;
        wcnt = 0; bphase = 0; bcnt = 0; setup_prev = 1'b0; busy_m = 1'b0;
        la = 16'h0; ld = 32'h0; status_m = 32'h0;
        pready = 1'b0; pslverr = 1'b0; prdata = 32'h0; sdsbusy = 1'b0; sdspi_status = 32'h0;
        forever begin
            @(negedge clk);
            case (bphase)
                1: if (bcnt == 0) begin
                       busy_m = 1'b1; status_m = 32'h0000_0300; bcnt = 100; bphase = 2;
                   end else bcnt--;
                2: begin
                       bcnt--;
                       if (bcnt == 0) begin
                           busy_m = 1'b0;
                           if (cfg_tail == 0) begin
                               status_m = 32'h0; clr_cyc = cyc; bphase = 0;
                           end else begin
                               bcnt = cfg_tail; bphase = 3;
                           end
                       end
                   end
                3: begin
                       bcnt--;
                       if (bcnt == 0) begin
                           status_m = 32'h0; clr_cyc = cyc; bphase = 0;
                       end
                   end
                default: ;
            endcase
            sdsbusy      = busy_m | force_busy;
            sdspi_status = status_m | force_status;
            pready  = 1'b0;
            pslverr = 1'b0;
            if (penable === 1'b1 && psel !== 1'b1) chk("penable_without_psel", 1, 0);
            if (psel === 1'b1 && penable !== 1'b1) begin
                chk("pwrite", pwrite, 1);
                if (setup_prev) chk("setup_not_followed_by_access", 1, 0);
                la = paddr; ld = pwdata; wcnt = 0; setup_prev = 1'b1;
            end else begin
                if (psel === 1'b1 && penable === 1'b1) begin
                    chk("paddr_stable", paddr, la);
                    chk("pwdata_stable", pwdata, ld);
                    if (wcnt < cfg_ws) wcnt++;
                    else begin
                        pready  = 1'b1;
                        pslverr = (apb_cnt == cfg_err);
                        if (sb_q.size() == 0) chk("apb_unexpected_transfer", 1, 0);
                        else begin
                            e = sb_q.pop_front();
                            chk("apb_transfer", {paddr, pwdata}, e);
                        end
                        if (paddr == WRCMD_ADDR && !pslverr) begin
                            cmd_cyc = cyc + 1;
                            if (cfg_busy_en) begin bphase = 1; bcnt = 2; end
                        end
                        apb_cnt++;
                    end
                end
                setup_prev = 1'b0;
            end
        end
    end

    task automatic arm(input vec_t v);
        cfg_ws = v.ws; cfg_err = v.err_idx; cfg_busy_en = v.busy_en; cfg_tail = v.tail;
        cur_sector = v.sector; exp_idx = 0; bytes_dlv = 0; apb_cnt = 0;
        sb_q.delete();
    endtask

    task automatic run_write(input string tag, input vec_t v, input bit hold);
        bit wd_seen;
        int wd_cyc;
        arm(v);
        wsector = v.sector;
        wstart  = 1'b1;
        wd_seen = 1'b0;
        wd_cyc  = 0;
        for (int i = 0; i < 40000 && !wd_seen; i++) begin
            @(negedge clk);
            if (i == 10) begin
                chk({tag, "_werr_cleared"}, werr, 0);
                wsector = 32'hDEAD_BEEF;
                if (!hold) wstart = 1'b0;
            end
            if (wdone === 1'b1) begin wd_seen = 1'b1; wd_cyc = cyc; end
        end
        chk({tag, "_wdone_seen"}, wd_seen, 1);
        chk({tag, "_werr"}, werr, v.exp_werr);
        if (!v.exp_werr) chk({tag, "_wdone_after_ctrl_idle"}, wd_cyc, clr_cyc + 1);
        else if (!v.busy_en && v.err_idx == NO_ERR) chk({tag, "_timeout_cycles"}, wd_cyc, cmd_cyc + 16);
        @(negedge clk);
        chk({tag, "_wdone_one_cycle"}, wdone, 0);
        repeat (3) @(negedge clk);
        chk({tag, "_bytes_fetched"}, bytes_dlv, v.exp_bytes);
        chk({tag, "_apb_transfers"}, apb_cnt, v.exp_apb);
        chk({tag, "_scoreboard_empty"}, sb_q.size(), 0);
        chk({tag, "_status"}, w_writer_status[23:0], {v.exp_werr, 7'b0, 16'(v.exp_count)});
    endtask

    initial begin
        vec_t v2;
        bit   seen, seen2, found;
        //            sector         ws  err_idx busy  tail werr bytes apb  count
        vecs[0] = '{32'h0000_1234, 0, NO_ERR, 1'b1, 0, 1'b0, 512, 513, 512};
        vecs[1] = '{32'hA5A5_0001, 5, NO_ERR, 1'b1, 0, 1'b0, 512, 513, 512};
        vecs[2] = '{32'h0000_0077, 1, 37,     1'b1, 0, 1'b1, 38,  38,  37};
        vecs[3] = '{32'h0000_0078, 0, 512,    1'b1, 0, 1'b1, 512, 513, 512};
        vecs[4] = '{32'h0000_0079, 0, NO_ERR, 1'b0, 0, 1'b1, 512, 513, 512};
        vecs[5] = '{32'h0BAD_F00D, 2, NO_ERR, 1'b1, 3, 1'b0, 512, 513, 512};

        rst = 1'b1; wstart = 1'b0; wsector = 32'h0;
        repeat (3) @(negedge clk);
        chk("rst_psel", psel, 0);
        chk("rst_penable", penable, 0);
        chk("rst_pwrite", pwrite, 0);
        chk("rst_paddr", paddr, 0);
        chk("rst_pwdata", pwdata, 0);
        chk("rst_inreq", inreq, 0);
        chk("rst_inaddr", inaddr, 0);
        chk("rst_wdone", wdone, 0);
        chk("rst_werr", werr, 0);
        chk("rst_status", w_writer_status[23:0], 0);
        rst = 1'b0;

        // Busy or non-zero controller state must block acceptance
        arm(vecs[0]);
        force_busy = 1'b1;
        @(negedge clk);
        wstart = 1'b1; wsector = 32'h0000_1234;
        seen = 1'b0;
        repeat (8) begin @(negedge clk); if (inreq === 1'b1) seen = 1'b1; end
        chk("gate_busy", seen, 0);
        force_status = 32'h0000_0001;
        @(negedge clk);
        force_busy = 1'b0;
        seen = 1'b0;
        repeat (8) begin @(negedge clk); if (inreq === 1'b1) seen = 1'b1; end
        chk("gate_status", seen, 0);
        wstart = 1'b0;
        repeat (2) @(negedge clk);
        force_status = 32'h0;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 6; v++) begin
            run_write($sformatf("vec%0d", v), vecs[v], 1'b0);
            wstart = 1'b0;
            repeat (3) @(negedge clk);
        end

        // Retrigger guard: wstart held through completion
        run_write("retrig1", vecs[0], 1'b1);
        seen = 1'b0;
        repeat (20) begin @(negedge clk); if (inreq === 1'b1 || psel === 1'b1) seen = 1'b1; end
        chk("retrig_no_second_write", seen, 0);
        chk("retrig_apb_count", apb_cnt, 513);
        wstart = 1'b0;
        repeat (3) @(negedge clk);
        v2 = vecs[0];
        v2.sector = 32'h0000_5678;
        run_write("retrig2", v2, 1'b0);
        wstart = 1'b0;
        repeat (3) @(negedge clk);

        // Reset during the access phase of byte 200
        arm(vecs[0]);
        wsector = 32'h0000_1234;
        wstart = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 10000 && !found; i++) begin
            @(negedge clk);
            if (psel === 1'b1 && penable === 1'b1 && paddr == BLOCKADDR + 16'd200) found = 1'b1;
        end
        chk("rst_mid_point_reached", found, 1);
        rst = 1'b1;
        wstart = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_psel", psel, 0);
        chk("rst_mid_penable", penable, 0);
        chk("rst_mid_paddr", paddr, 0);
        chk("rst_mid_pwdata", pwdata, 0);
        chk("rst_mid_inaddr", inaddr, 0);
        chk("rst_mid_status", w_writer_status[23:0], 0);
        seen = 1'b0; seen2 = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (wdone === 1'b1) seen = 1'b1;
            if (inreq === 1'b1 || psel === 1'b1) seen2 = 1'b1;
        end
        chk("rst_mid_no_wdone", seen, 0);
        chk("rst_mid_stays_idle", seen2, 0);
        run_write("after_rst", vecs[0], 1'b0);
        wstart = 1'b0;
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
